// File: rtl/ripple_carry_adder_reg_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands and consumes results; the slave is the adder.
interface ripple_carry_adder_reg_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, ovf, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, ovf, out_valid
    );
endinterface

// File: rtl/ripple_carry_adder_reg.sv
// Single-cycle registered ripple-carry adder: A + B + cin through a chain of
// 1-bit full-adder stages, with sum, carry-out and signed overflow captured
// on the clock edge whenever the operands are flagged valid.
module ripple_carry_adder_reg #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ripple_carry_adder_reg_if.slave    bus
);

    logic [WIDTH:0]   carryChain;
    logic [WIDTH-1:0] stageSum;
    logic             ovfNext;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             outValid_d, outValid_q;

    // Ripple the carry through one full-adder stage per bit, LSB first.
    always_comb begin
        carryChain    = '0;
        stageSum      = '0;
        carryChain[0] = bus.cin;
        for (int i = 0; i < WIDTH; i++) begin
            stageSum[i]     = bus.a[i] ^ bus.b[i] ^ carryChain[i];
            carryChain[i+1] = (bus.a[i] & bus.b[i])
                            | (bus.a[i] & carryChain[i])
                            | (bus.b[i] & carryChain[i]);
        end
        ovfNext = carryChain[WIDTH] ^ carryChain[WIDTH-1];
    end

    // Load a new result only on valid operands so idle inputs never disturb the held outputs.
    always_comb begin
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        outValid_d = 1'b0;
        if (bus.in_valid) begin
            sum_d      = stageSum;
            cout_d     = carryChain[WIDTH];
            ovf_d      = ovfNext;
            outValid_d = 1'b1;
        end
    end

    // Result registers; reset wins over a simultaneous valid and drops any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_ripple_carry_adder_reg.sv
// Testbench for the registered ripple-carry adder (WIDTH=4): directed vector
// table, reset/hold/mid-stream-reset sequences, exhaustive and random sweeps
// checked against an arithmetic reference model.
module tb_ripple_carry_adder_reg;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] expSum;
        logic         expCout;
        logic         expOvf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    ripple_carry_adder_reg_if #(.WIDTH(W)) bus ();

    ripple_carry_adder_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mdlSum;
    logic         mdlCout;
    logic         mdlOvf;
    logic         mdlValid;

    vec_t vecs [7];

    // Reference model: plain integer arithmetic on unsigned and signed views.
    task automatic modelStep(input logic rstN, input logic inValid,
                             input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv);
        int uRes;
        int sRes;
        if (!rstN) begin
            mdlSum   = '0;
            mdlCout  = 1'b0;
            mdlOvf   = 1'b0;
            mdlValid = 1'b0;
        end else if (inValid) begin
            uRes     = int'(av) + int'(bv) + int'(cv);
            sRes     = int'($signed(av)) + int'($signed(bv)) + int'(cv);
            mdlSum   = uRes[W-1:0];
            mdlCout  = uRes[W];
            mdlOvf   = (sRes > (2 ** (W - 1)) - 1) || (sRes < -(2 ** (W - 1)));
            mdlValid = 1'b1;
        end else begin
            mdlValid = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, land on the falling edge for sampling.
    task automatic applyStimulus(input logic rstN, input logic inValid,
                                 input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv);
        rst_n        = rstN;
        bus.in_valid = inValid;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = cv;
        modelStep(rstN, inValid, av, bv, cv);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] eSum,
                               input logic eCout, input logic eOvf, input logic eValid);
        total++;
        if ({bus.sum, bus.cout, bus.ovf, bus.out_valid} !== {eSum, eCout, eOvf, eValid}) begin
            bad++;
            $display("[TB] FAIL %s: got sum=%h cout=%b ovf=%b out_valid=%b, want sum=%h cout=%b ovf=%b out_valid=%b",
                     name, bus.sum, bus.cout, bus.ovf, bus.out_valid, eSum, eCout, eOvf, eValid);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mdlSum, mdlCout, mdlOvf, mdlValid);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rv;
        logic         rr;

        vecs[0] = '{a: 4'b1111, b: 4'b0001, cin: 1'b0, expSum: 4'b0000, expCout: 1'b1, expOvf: 1'b0};
        vecs[1] = '{a: 4'b1111, b: 4'b1111, cin: 1'b1, expSum: 4'b1111, expCout: 1'b1, expOvf: 1'b0};
        vecs[2] = '{a: 4'b0000, b: 4'b0000, cin: 1'b1, expSum: 4'b0001, expCout: 1'b0, expOvf: 1'b0};
        vecs[3] = '{a: 4'b0111, b: 4'b0001, cin: 1'b0, expSum: 4'b1000, expCout: 1'b0, expOvf: 1'b1};
        vecs[4] = '{a: 4'b1000, b: 4'b1000, cin: 1'b0, expSum: 4'b0000, expCout: 1'b1, expOvf: 1'b1};
        vecs[5] = '{a: 4'b0101, b: 4'b0101, cin: 1'b0, expSum: 4'b1010, expCout: 1'b0, expOvf: 1'b1};
        vecs[6] = '{a: 4'b1100, b: 4'b0011, cin: 1'b1, expSum: 4'b0000, expCout: 1'b1, expOvf: 1'b0};

        // Reset held for two edges while operands claim to be valid.
        applyStimulus(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
        checkOutput("reset_edge1", 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
        checkOutput("reset_edge2", 4'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'hF, 4'hF, 1'b1);
        checkOutput("reset_release_idle", 4'h0, 1'b0, 1'b0, 1'b0);

        // Directed carry/overflow table, back-to-back.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput($sformatf("table_%0d", i), vecs[i].expSum, vecs[i].expCout,
                        vecs[i].expOvf, 1'b1);
        end

        // Hold: idle cycles with changed operands must not move the result.
        applyStimulus(1'b1, 1'b1, 4'd3, 4'd4, 1'b0);
        checkOutput("hold_capture", 4'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd9, 4'd9, 1'b0);
            checkOutput($sformatf("hold_idle_%0d", i), 4'd7, 1'b0, 1'b0, 1'b0);
        end

        // Mid-stream reset discards the in-flight result.
        applyStimulus(1'b1, 1'b1, 4'd1, 4'd1, 1'b0);
        checkOutput("stream_op0", 4'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 4'd6, 4'd6, 1'b1);
        checkOutput("stream_op1", 4'd13, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'd9, 4'd3, 1'b0);
        checkOutput("midstream_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd5, 1'b1);
        checkOutput("post_reset_op", 4'd8, 1'b0, 1'b1, 1'b1);

        // Exhaustive sweep with in_valid every cycle.
        for (int c = 0; c < 2; c++) begin
            for (int v = 0; v < 256; v++) begin
                ra = W'(v >> 4);
                rb = W'(v);
                applyStimulus(1'b1, 1'b1, ra, rb, c[0]);
                checkModel($sformatf("exh_c%0d_a%0h_b%0h", c, ra, rb));
            end
        end

        // Random mix of valid, idle and occasional reset cycles.
        for (int i = 0; i < 400; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 31) != 0);
            applyStimulus(rr, rv, ra, rb, rc);
            checkModel($sformatf("rand_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder_reg.md
Name: ripple_carry_adder_reg

Overview:
- Parameterizable unsigned/two's-complement ripple-carry adder: A + B + carry-in, built as an explicit chain of 1-bit full-adder stages.
- Result, carry-out and signed-overflow flag are registered on one clock, so the block drops into synchronous datapaths as a single-cycle arithmetic stage.
- Default configuration is the 4-bit adder used by the unit-level datapath.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out of bit WIDTH-1.
- ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  sum/cout/ovf were updated by the previous edge.

Behaviour:
- Datapath is a ripple chain of WIDTH full-adder stages, with c[0] = cin.
- Each stage i computes s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
- No carry-lookahead, and no behavioural '+' on the full vector.
- Combinational result: {c[WIDTH], s} equals a + b + cin exactly, treated as a (WIDTH+1)-bit unsigned result.
- ovf_next = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, c[0] is cin.
- Reset:
  - On a rising edge with rst_n=0, sum, cout, ovf and out_valid all go to 0.
  - Reset has priority over in_valid.
  - Reset asserted mid-stream discards the in-flight result; the first post-reset out_valid requires a new in_valid.
- Capture: on a rising edge with rst_n=1 and in_valid=1, register sum=s, cout=c[WIDTH], ovf=ovf_next, out_valid=1.
- Hold: on a rising edge with rst_n=1 and in_valid=0, sum, cout and ovf hold their previous values and out_valid goes to 0.
- Latency: exactly 1 clock from the in_valid edge to the out_valid/result edge. Throughput is one operation per clock; back-to-back in_valid is fully supported.
- Wrap-around: the sum is modulo 2^WIDTH and the overflow bit goes to cout. Example (WIDTH=4): 4'hF + 4'h1 gives sum=0, cout=1.
- No backpressure; the consumer must accept each out_valid pulse.
- Inputs only need to be stable around the clock edge; there is no combinational path from any input to any output.
- X on inputs while in_valid=0 must not corrupt the held outputs.

Test Plan:
- Reset: rst_n=0 for 2 edges with in_valid=1, a=4'hF, b=4'hF, cin=1 -> sum=0, cout=0, ovf=0, out_valid=0. Release rst_n -> still out_valid=0 until the next in_valid edge.
- Exhaustive (WIDTH=4): for cin in {0,1}, drive {a,b} = 0..255 with in_valid=1 every cycle, 512 vectors total.
  - Each result appears one cycle later with {cout,sum} = a+b+cin.
  - out_valid stays high continuously.
- Carry ripple / wrap-around:
  - a=4'b1111, b=4'b0001, cin=0 -> sum=4'b0000, cout=1, ovf=0.
  - a=4'b1111, b=4'b1111, cin=1 -> sum=4'b1111, cout=1, ovf=0.
  - a=0, b=0, cin=1 -> sum=4'b0001, cout=0.
- Signed overflow:
  - a=4'b0111, b=4'b0001, cin=0 -> sum=4'b1000, cout=0, ovf=1.
  - a=4'b1000, b=4'b1000, cin=0 -> sum=4'b0000, cout=1, ovf=1.
- Hold: capture a=3, b=4, cin=0 (sum=7), then drive in_valid=0 with a=9, b=9 for 3 cycles -> sum stays 7, cout=0, out_valid=1 for one cycle then 0.
- Mid-stream reset: back-to-back valid ops, assert rst_n=0 for one edge -> all outputs 0 that edge. The next in_valid op a=2, b=5, cin=1 -> sum=8, out_valid=1 after 1 cycle.
